// File: rtl/ntt_radix8_loader_pkg.sv
// ntt_radix8_loader_pkg
// Shared constants and helpers for the radix-8 NTT datapath.
//   DEF_WIDTH / DEF_Q / DEF_N : default coefficient width, modulus, frame length
//   LANES                     : butterfly lanes per group
//   mod_red_2q()              : conditional subtract [0,2Q) -> [0,Q); also used
//                               on butterfly outputs
//   lane_lsb()                : bit offset of a lane in a packed lane vector
package ntt_radix8_loader_pkg;

  localparam int unsigned DEF_WIDTH = 18;
  localparam int unsigned DEF_Q     = 65537;
  localparam int unsigned DEF_N     = 64;
  localparam int unsigned LANES     = 8;

  // Operates on 32-bit values so any WIDTH up to 32 can share it; callers
  // truncate the result back to their own width.
  function automatic logic [31:0] mod_red_2q(input logic [31:0] x, input logic [31:0] q);
    return (x >= q) ? (x - q) : x;
  endfunction

  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/ntt_radix8_loader_if.sv
// ntt_radix8_loader_if
// Coefficient input stream and packed group output of the NTT loader.
//   in_valid/in_ready/in_data          : one coefficient per transfer
//   out_valid/out_ready                : one 8-lane group per transfer
//   out_lanes                          : lane k at [k*WIDTH +: WIDTH]
//   out_group / out_last               : group index in frame, last-group flag
// Modports: master = producer/consumer side, slave = loader.
interface ntt_radix8_loader_if
  import ntt_radix8_loader_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned GW    = 3
);

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_lanes;
  logic [GW-1:0]          out_group;
  logic                   out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_lanes, out_group, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_lanes, out_group, out_last
  );

endinterface

// File: rtl/ntt_radix8_loader_mod_reduce.sv
// ntt_radix8_loader_mod_reduce
// Combinational reducer from [0,2Q) to [0,Q) with out-of-range flag.
//   x    : input coefficient
//   y    : x >= Q ? x - Q : x, truncated to WIDTH
//   over : x >= 2Q (result is then not a proper residue)
module ntt_radix8_loader_mod_reduce
  import ntt_radix8_loader_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned Q     = DEF_Q
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             over
);

  assign y    = WIDTH'(mod_red_2q(32'(x), 32'(Q)));
  assign over = (33'(x) >= (33'(Q) << 1));

endmodule

// File: rtl/ntt_radix8_loader.sv
// ntt_radix8_loader
// Streaming front end of the radix-8 NTT core: reduces incoming coefficients,
// packs 8 of them per group into ping-pong banks and presents each group in
// parallel with its index within the frame.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : synchronous flush of banks and counters (err_range kept)
//   bus       : ntt_radix8_loader_if slave (input stream, group output)
//   err_range : sticky, set when a sample >= 2Q was accepted
module ntt_radix8_loader
  import ntt_radix8_loader_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned Q     = DEF_Q,
  parameter int unsigned N     = DEF_N
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  ntt_radix8_loader_if.slave   bus,
  output logic                 err_range
);

  localparam int unsigned GROUPS = N / LANES;
  localparam int unsigned GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [GW-1:0] LAST_GRP = GW'(GROUPS - 1);

  logic [WIDTH-1:0] bank_q [2][LANES];
  logic             wr_bank;
  logic             rd_bank;
  logic [2:0]       wr_lane;
  logic [1:0]       full_cnt;
  logic [GW-1:0]    grp_q;

  logic [WIDTH-1:0] red_data;
  logic             red_over;
  logic             in_fire;
  logic             out_fire;
  logic             grp_done;

  ntt_radix8_loader_mod_reduce #(.WIDTH(WIDTH), .Q(Q)) u_red (
    .x    (bus.in_data),
    .y    (red_data),
    .over (red_over)
  );

  // Depends only on registered occupancy, never on out_ready.
  assign bus.in_ready  = (full_cnt != 2'd2) && !rst;
  assign bus.out_valid = (full_cnt != 2'd0);
  assign bus.out_group = grp_q;
  assign bus.out_last  = bus.out_valid && (grp_q == LAST_GRP);

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;
  assign grp_done = in_fire && (wr_lane == 3'd7);

  always_comb begin
    bus.out_lanes = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      bus.out_lanes[lane_lsb(k, WIDTH) +: WIDTH] = bank_q[rd_bank][3'(k)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned k = 0; k < LANES; k++) begin
          bank_q[b][k] <= '0;
        end
      end
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      wr_lane  <= 3'd0;
      full_cnt <= 2'd0;
      grp_q    <= '0;
      if (rst) begin
        err_range <= 1'b0;
      end
    end else begin
      if (in_fire) begin
        bank_q[wr_bank][wr_lane] <= red_data;
        wr_lane <= wr_lane + 3'd1;
        if (red_over) begin
          err_range <= 1'b1;
        end
        if (wr_lane == 3'd7) begin
          wr_bank <= ~wr_bank;
        end
      end
      if (out_fire) begin
        rd_bank <= ~rd_bank;
        grp_q   <= (grp_q == LAST_GRP) ? '0 : grp_q + GW'(1);
      end
      // A group finishing while another leaves keeps occupancy unchanged.
      case ({grp_done, out_fire})
        2'b10:   full_cnt <= full_cnt + 2'd1;
        2'b01:   full_cnt <= full_cnt - 2'd1;
        default: full_cnt <= full_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_radix8_loader.sv
module tb_ntt_radix8_loader;
  import ntt_radix8_loader_pkg::*;

  localparam int unsigned W  = 18;
  localparam int unsigned GW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic err_range;

  ntt_radix8_loader_if #(.WIDTH(W), .GW(GW)) bus ();

  ntt_radix8_loader #(.WIDTH(W), .Q(65537), .N(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .bus       (bus),
    .err_range (err_range)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8*W-1:0] lanes;
    logic [GW-1:0]  grp;
    logic           last;
  } grp_t;

  grp_t           exp_q[$];
  int             checks = 0;
  int             errors = 0;
  logic [8*W-1:0] cur_lanes = '0;
  int             cur_n = 0;
  logic [GW-1:0]  exp_grp = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one sample; exp is the hand-computed reduced value for its lane.
  task automatic send(input logic [W-1:0] raw, input logic [W-1:0] exp, output int stalls);
    stalls = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = raw;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        cur_lanes[cur_n*W +: W] = exp;
        cur_n++;
        if (cur_n == 8) begin
          exp_q.push_back('{lanes: cur_lanes, grp: exp_grp, last: (exp_grp == 3'd7)});
          exp_grp = exp_grp + 3'd1;
          cur_n = 0;
        end
        return;
      end
      stalls++;
    end
    bus.in_valid = 1'b0;
    checks++;
    errors++;
    $display("FAIL send_timeout: in_ready stayed %0d for 200 cycles, required 1", bus.in_ready);
  endtask

  task automatic drain();
    for (int c = 0; c < 60; c++) begin
      if (exp_q.size() == 0) begin
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: %0d groups pending, required 0", exp_q.size());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    cur_n = 0;
    exp_grp = '0;
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    cur_n = 0;
    exp_grp = '0;
  endtask

  // Scoreboard monitor: compares every group actually transferred.
  always @(negedge clk) begin
    grp_t e;
    if (!rst && !clear && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_group: group %0d presented, required none", bus.out_group);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (bus.out_lanes !== e.lanes) begin
          errors++;
          $display("FAIL group_lanes: got %h expected %h", bus.out_lanes, e.lanes);
        end
        chk("group_index", 64'(bus.out_group), 64'(e.grp));
        chk("group_last", 64'(bus.out_last), 64'(e.last));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] t2_raw [8];
  logic [W-1:0] t2_exp [8];

  initial begin
    int s;
    int total;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    t2_raw = '{18'd65537, 18'd65538, 18'd131073, 18'd5, 18'd0, 18'd65536, 18'd1, 18'd2};
    t2_exp = '{18'd0, 18'd1, 18'd65536, 18'd5, 18'd0, 18'd65536, 18'd1, 18'd2};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_lanes", 64'(|bus.out_lanes), 64'd0);
    chk("rst_out_group", 64'(bus.out_group), 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_err_range", 64'(err_range), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Samples 0..7, out_valid in the cycle after the 8th
    for (int i = 0; i < 8; i++) send(W'(i), W'(i), s);
    chk("t1_out_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_out_group", 64'(bus.out_group), 64'd0);
    chk("t1_out_last", 64'(bus.out_last), 64'd0);
    drain();

    // Reduction of values in [0,2Q)
    for (int i = 0; i < 8; i++) send(t2_raw[i], t2_exp[i], s);
    drain();
    chk("t2_err_range", 64'(err_range), 64'd0);

    // 2Q is flagged, stored as 2Q-Q, flag survives clear, drops on rst
    send(18'd131074, 18'd65537, s);
    for (int i = 1; i < 8; i++) send(W'(10 + i), W'(10 + i), s);
    drain();
    chk("t3_err_set", 64'(err_range), 64'd1);
    do_clear();
    chk("t3_err_after_clear", 64'(err_range), 64'd1);
    chk("t3_valid_after_clear", 64'(bus.out_valid), 64'd0);
    do_reset();
    chk("t3_err_after_rst", 64'(err_range), 64'd0);
    chk("t3_in_ready_after_rst", 64'(bus.in_ready), 64'd1);

    // Back-pressure: both banks fill, one transfer frees a bank
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(W'(100 + i), W'(100 + i), s);
    chk("t4_in_ready_full", 64'(bus.in_ready), 64'd0);
    chk("t4_out_valid_full", 64'(bus.out_valid), 64'd1);
    chk("t4_group_held", 64'(bus.out_group), 64'd0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("t4_in_ready_back", 64'(bus.in_ready), 64'd1);
    chk("t4_second_valid", 64'(bus.out_valid), 64'd1);
    chk("t4_second_group", 64'(bus.out_group), 64'd1);
    chk("t4_pending", 64'(exp_q.size()), 64'd1);
    bus.out_ready = 1'b1;
    drain();

    // Full frame at one sample per cycle, then wrap to group 0
    do_reset();
    total = 0;
    for (int i = 0; i < 64; i++) begin
      send(W'(1000 + i), W'(1000 + i), s);
      total += s;
    end
    chk("t5_stalls", 64'(total), 64'd0);
    for (int i = 0; i < 8; i++) send(W'(2000 + i), W'(2000 + i), s);
    chk("t5_wrap_group", 64'(bus.out_group), 64'd0);
    drain();

    // Clear drops a partial group and the same-cycle sample
    for (int i = 0; i < 5; i++) send(W'(300 + i), W'(300 + i), s);
    bus.in_valid = 1'b1;
    bus.in_data  = 18'd999;
    do_clear();
    chk("t6_valid_after_clear", 64'(bus.out_valid), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_valid_idle", 64'(bus.out_valid), 64'd0);
    for (int i = 0; i < 8; i++) send(W'(400 + i), W'(400 + i), s);
    chk("t6_fresh_group", 64'(bus.out_group), 64'd0);
    drain();

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
